// File: rtl/key_lut_debounce.sv
// Key synchroniser, per-key debouncer and programmable truth-table LED driver.
// The LED follows f directly (MODE 0) or toggles on each rising edge of f (MODE 1).

module key_lut_debounce_lane #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CW              = 5
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic key_i,
    output logic stable_o,
    output logic upd_o
);
    logic          s1_q, s2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any cycle where s2 matches the stable value clears the count,
    // so a bounce restarts the whole qualification window.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        upd_o    = 1'b0;
        if (s2_q != stable_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = s2_q;
                upd_o    = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= key_i;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;
endmodule

module key_lut_debounce #(
    parameter int                      N_KEYS          = 4,
    parameter int                      DEBOUNCE_CYCLES = 16,
    parameter logic [(2**N_KEYS)-1:0]  TRUTH_TABLE     = 16'h6996,
    parameter int                      MODE            = 0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [N_KEYS-1:0] key_i,
    output logic [N_KEYS-1:0] keys_stable_o,
    output logic              change_pulse_o,
    output logic              led_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    if (N_KEYS < 1 || N_KEYS > 8) begin : g_bad_keys
        $error("key_lut_debounce: N_KEYS must be in 1..8");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
        $error("key_lut_debounce: DEBOUNCE_CYCLES must be >= 1");
    end

    logic [N_KEYS-1:0] upd;
    logic              change_pulse_q;
    logic              f, f_q;
    logic              led_q, led_d;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_lane
        key_lut_debounce_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CW             (CW)
        ) u_lane (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .key_i   (key_i[i]),
            .stable_o(keys_stable_o[i]),
            .upd_o   (upd[i])
        );
    end

    assign f = TRUTH_TABLE[keys_stable_o];

    always_comb begin
        if (MODE == 0) led_d = f;
        else           led_d = led_q ^ (f & ~f_q);
    end

    // f_q starts at the table value for all-keys-released so MODE 1 sees no
    // false rising edge when reset is released.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            change_pulse_q <= 1'b0;
            f_q            <= TRUTH_TABLE[0];
            led_q          <= 1'b0;
        end else begin
            change_pulse_q <= |upd;
            f_q            <= f;
            led_q          <= led_d;
        end
    end

    assign change_pulse_o = change_pulse_q;
    assign led_o          = led_q;
endmodule

// File: tb/tb_key_lut_debounce.sv
// Directed bench: level-mode parity instance plus toggle-mode AND-of-all-keys instance.

module tb_key_lut_debounce;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key0, key1;
    logic [3:0] ks0, ks1;
    logic       cp0, cp1, led0, led1;

    int n_chk  = 0;
    int n_pass = 0;

    key_lut_debounce #(.N_KEYS(4), .DEBOUNCE_CYCLES(4), .TRUTH_TABLE(16'h6996), .MODE(0)) u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .key_i(key0),
        .keys_stable_o(ks0), .change_pulse_o(cp0), .led_o(led0)
    );

    key_lut_debounce #(.N_KEYS(4), .DEBOUNCE_CYCLES(4), .TRUTH_TABLE(16'h8000), .MODE(1)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .key_i(key1),
        .keys_stable_o(ks1), .change_pulse_o(cp1), .led_o(led1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] prev, nv;
        int pulses, bad, ks_bad, led_bad;

        rst_n = 1'b0;
        key0  = '0;
        key1  = '0;
        step(2);
        chk("rst_ks0", ks0, 0);
        chk("rst_cp0", cp0, 0);
        chk("rst_led0", led0, 0);
        chk("rst_ks1_cp1_led1", {ks1, cp1, led1}, 0);
        rst_n = 1'b1;
        step(1);

        // 1: sweep, led == parity 7 edges after each change
        for (int v = 0; v < 16; v++) begin
            prev = key0;
            nv   = v[3:0];
            key0 = nv;
            step(5);
            chk("t1_ks_hold", ks0, prev);
            step(1);
            chk("t1_ks", ks0, nv);
            chk("t1_led_old", led0, ^prev);
            if (v != 0) chk("t1_pulse", cp0, 1);
            step(1);
            chk("t1_led", led0, ^nv);
            chk("t1_pulse_off", cp0, 0);
            step(5);
        end

        // 2: bounce on key[0]
        key0 = '0;
        step(12);
        chk("t2_pre", ks0, 0);
        pulses = 0;
        bad    = 0;
        for (int i = 0; i < 10; i++) begin
            key0[0] = ~key0[0];
            repeat (2) begin
                step(1);
                if (ks0[0]) bad++;
                pulses += int'(cp0);
            end
        end
        key0[0] = 1'b1;
        repeat (5) begin
            step(1);
            pulses += int'(cp0);
        end
        chk("t2_ks_edge5", ks0[0], 0);
        step(1);
        pulses += int'(cp0);
        chk("t2_ks_edge6", ks0[0], 1);
        repeat (6) begin
            step(1);
            pulses += int'(cp0);
        end
        chk("t2_bounce_ks", bad, 0);
        chk("t2_pulses", pulses, 1);

        // 3: 3-cycle glitch on key[2]
        chk("t3_pre_led", led0, 1);
        key0[2] = 1'b1;
        step(3);
        key0[2] = 1'b0;
        pulses = 0; ks_bad = 0; led_bad = 0;
        repeat (12) begin
            step(1);
            if (ks0 != 4'b0001) ks_bad++;
            if (led0 != 1'b1) led_bad++;
            pulses += int'(cp0);
        end
        chk("t3_ks", ks_bad, 0);
        chk("t3_pulses", pulses, 0);
        chk("t3_led", led_bad, 0);

        // 4: two keys settle on the same edge
        key0 = '0;
        step(12);
        key0 = 4'b0011;
        pulses = 0;
        repeat (5) begin
            step(1);
            pulses += int'(cp0);
        end
        chk("t4_ks_edge5", ks0, 0);
        step(1);
        pulses += int'(cp0);
        chk("t4_ks_edge6", ks0, 4'b0011);
        repeat (5) begin
            step(1);
            pulses += int'(cp0);
        end
        chk("t4_pulses", pulses, 1);
        chk("t4_led", led0, 0);

        // 5: toggle mode
        key1 = 4'b1111;
        step(6);
        chk("t5_led_pre", led1, 0);
        step(1);
        chk("t5_led_on", led1, 1);
        key1 = 4'b0000;
        step(12);
        chk("t5_led_hold", led1, 1);
        key1 = 4'b1111;
        step(12);
        chk("t5_led_off", led1, 0);

        // 6: asynchronous reset while key[1] is mid-count
        key0 = 4'b0001;
        step(12);
        chk("t6_pre_ks", ks0, 4'b0001);
        chk("t6_pre_led", led0, 1);
        key0 = 4'b0011;
        step(4);
        rst_n = 1'b0;
        #1;
        chk("t6_async_ks0", ks0, 0);
        chk("t6_async_led0", led0, 0);
        chk("t6_async_cp0", cp0, 0);
        chk("t6_async_ks1", ks1, 0);
        step(2);
        rst_n = 1'b1;
        step(5);
        chk("t6_ks_edge5", ks0, 0);
        step(1);
        chk("t6_ks_edge6", ks0, 4'b0011);
        chk("t6_ks1_edge6", ks1, 4'b1111);
        step(1);
        chk("t6_led1_toggle", led1, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
